// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM states
// and a small address helper.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic addr_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: one synchronous write port, combinational read.
// Deliberately has no reset so contents survive a responder reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Word write on the clock edge.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed LATENCY and a held response.
// Optional misaligned-address rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              op_write_s;
  logic [AW+1:0]     op_addr_s;
  logic [WORD_W-1:0] op_wdata_s;
  logic              enter_resp_s;
  logic              misaligned_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] mem_rdata_s;
  logic              addr_unused;

  // With LATENCY=1 the array is accessed on the acceptance edge itself, so the
  // operation comes straight from the request inputs while still in IDLE.
  always_comb begin
    op_write_s = write_q;
    op_addr_s  = addr_q;
    op_wdata_s = wdata_q;
    if (state_q == IDLE) begin
      op_write_s = req_write;
      op_addr_s  = req_addr[AW+1:0];
      op_wdata_s = req_wdata;
    end else begin
      op_write_s = write_q;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned_s = addr_misaligned(op_addr_s[1:0]);
  assign addr_unused  = ^req_addr[WORD_W-1:AW+2];
`else
  assign misaligned_s = 1'b0;
  assign addr_unused  = ^{req_addr[WORD_W-1:AW+2], op_addr_s[1:0]};
`endif

  // Next-state, latch and response-capture logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = {WORD_W{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    if (enter_resp_s) begin
      err_d   = misaligned_s;
      rdata_d = (op_write_s || misaligned_s) ? {WORD_W{1'b0}} : mem_rdata_s;
    end else begin
      err_d = err_d;
    end
  end

  assign mem_we_s = enter_resp_s && op_write_s && !misaligned_s;

  // State and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= {WORD_W{1'b0}};
      rdata_q <= {WORD_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .we_i   (mem_we_s),
    .waddr_i(op_addr_s[AW+1:2]),
    .wdata_i(op_wdata_s),
    .raddr_i(op_addr_s[AW+1:2]),
    .rdata_o(mem_rdata_s)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2): vector table
// plus hand sequences for reset aborts and the optional alignment check.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One full transaction; request inputs are scrambled after acceptance.
  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    check({tag, " ready_idle"}, req_ready, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      check({tag, " ready_wait"}, req_ready, 32'd0);
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, LAT);
    for (int i = 0; i < hold; i++) begin
      check({tag, " hold_valid"}, resp_valid, 32'd1);
      check({tag, " hold_rdata"}, resp_rdata, exp_rdata);
      check({tag, " hold_ready"}, req_ready, 32'd0);
      @(posedge clock); #1;
    end
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, resp_err, exp_err);
    check({tag, " ready_resp"}, req_ready, 32'd0);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check({tag, " done_valid"}, resp_valid, 32'd0);
    check({tag, " done_ready"}, req_ready, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 5, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0400, 32'h1234_5678, 0, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1, 32'h1234_5678, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 0, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 0, 32'h1111_1111, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 2, 32'h0000_0000, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_F7FC, 32'h0000_0000, 0, 32'hCAFE_F00D, 1'b0};

    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", req_ready, 32'd1);
    check("rst_valid", resp_valid, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", resp_err, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < 8; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata,
              vecs[v].hold, vecs[v].exp_rdata, vecs[v].exp_err);
    end

`ifdef DMEM_ALIGN_CHECK_EN
    run_txn("misalign_load", 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 1'b1);
`else
    run_txn("offset_ignored", 1'b0, 32'h0000_0013, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
`endif

    // Reset during WAIT of a store: the store must never land.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0020;
    req_wdata = 32'hAAAA_5555;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("abort_in_wait", resp_valid, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_ready", req_ready, 32'd1);
    check("abort_valid", resp_valid, 32'd0);
    check("abort_rdata", resp_rdata, 32'd0);
    check("abort_err", resp_err, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_txn("after_abort", 1'b0, 32'h0000_0020, 32'h0, 0, 32'h1111_1111, 1'b0);

    // Reset while a load response is being held.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0010;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    check("resp_abort_pre_valid", resp_valid, 32'd1);
    check("resp_abort_pre_rdata", resp_rdata, 32'hDEAD_BEEF);
    reset = 1'b0;
    #1;
    check("resp_abort_valid", resp_valid, 32'd0);
    check("resp_abort_rdata", resp_rdata, 32'd0);
    check("resp_abort_ready", req_ready, 32'd1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

`ifdef DMEM_ALIGN_CHECK_EN
    run_txn("misalign_store", 1'b1, 32'h0000_0022, 32'h9999_9999, 0, 32'h0, 1'b1);
    run_txn("misalign_check", 1'b0, 32'h0000_0020, 32'h0, 0, 32'h1111_1111, 1'b0);
`else
    run_txn("final_load", 1'b0, 32'h0000_0400, 32'h0, 0, 32'h1234_5678, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit storage words (power of two, at least 2).
REQ-002 Parameter LATENCY, default 2, SHALL set the cycles from request acceptance to response valid (at least 1).
REQ-003 clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  the CPU-side initiator presents a load/store request.
REQ-006 req_ready  out  1  the responder can accept a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 resp_valid  out  1  response available.
REQ-011 resp_ready  in  1  the initiator accepts the response.
REQ-012 resp_rdata  out  32  load data; 0 for stores.
REQ-013 resp_err  out  1  the request was rejected (ALIGN_CHECK_EN only).

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP; only one request is outstanding at a time.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-016 On acceptance, req_write, req_addr and req_wdata SHALL be latched; later changes on the request inputs are ignored until the next IDLE.
REQ-017 Acceptance SHALL go to WAIT with the counter loaded to LATENCY-1, or directly to RESP when LATENCY=1.
REQ-018 In WAIT the counter SHALL decrement once per cycle; on the edge where it reaches 0 the FSM goes to RESP.
REQ-019 If acceptance is at edge N, resp_valid SHALL first be 1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles later.
REQ-020 A store SHALL be written into the array on the edge entering RESP.
REQ-021 Load data SHALL be captured into resp_rdata on the edge entering RESP.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready=1; that edge returns the FSM to IDLE.
REQ-023 There SHALL be no IDLE bypass, so back-to-back requests are spaced by at least LATENCY+1 cycles.
REQ-024 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-025 A load issued after a completed store to the same word SHALL return the stored data.

Reset
REQ-026 While reset=0: FSM in IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 Reset asserted mid-operation (WAIT or RESP) SHALL abort the transaction; a store not yet committed is discarded.
REQ-028 The storage array SHALL NOT be cleared by reset.

Configuration
REQ-029 With macro DMEM_ALIGN_CHECK_EN defined, req_addr[1:0]!=0 SHALL give resp_err=1, resp_rdata=0, no array write, and the same LATENCY.
REQ-030 Without DMEM_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and resp_err SHALL be tied to 0.

Structure
REQ-031 The shared package mips_pkg SHALL hold WORD_W=32 and the state enumeration (IDLE, WAIT, RESP).
REQ-032 The storage SHALL be a sub-module dmem_array: a synchronous write port, combinational read, DEPTH_WORDS x 32.

Verification
REQ-033 Reset release, then store 0xDEADBEEF to address 0x10 -> resp_valid exactly 2 cycles after acceptance, resp_rdata=0, resp_err=0.
REQ-034 Load from 0x10 after REQ-033 -> resp_rdata=0xDEADBEEF; req_ready=0 throughout WAIT and RESP.
REQ-035 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable for all 5; return to IDLE on the edge where resp_ready=1.
REQ-036 Store 0x12345678 to address 0x400 (DEPTH_WORDS=256), then load from 0x0 -> 0x12345678 (wrap-around).
REQ-037 Assert reset in WAIT during a store of 0xAAAA5555 to 0x20 (previously 0x11111111) -> outputs at reset values immediately; a later load of 0x20 returns 0x11111111.
REQ-038 With DMEM_ALIGN_CHECK_EN defined, store to 0x22 -> resp_err=1 after LATENCY cycles; a later load of word 0x20 is unchanged.
